// File: rtl/fitness_sweeper.sv
// fitness_sweeper: sweeps every input vector onto an evolvable circuit,
// waits for it to settle, compares its outputs against a target truth table
// and reports the count of matching output bits as the fitness.
module fitness_sweeper #(
  parameter  int IN     = 2,
  parameter  int OUT    = 1,
  parameter  int SETTLE = 1,
  localparam int NV     = 2**IN,
  localparam int FW     = $clog2(OUT*NV+1),
  localparam int WW     = $clog2(SETTLE+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [OUT*NV-1:0]  target,
  input  logic [OUT-1:0]     out_dut,
  output logic [IN-1:0]      inp,
  output logic               busy,
  output logic               done,
  output logic [FW-1:0]      fitness,
  output logic               perfect
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [IN:0]   VEC_LAST = (IN+1)'(NV-1);
  localparam logic [WW-1:0] WAIT_END = WW'(SETTLE);
  localparam logic [FW-1:0] FIT_MAX  = FW'(OUT*NV);

  state_t          state, state_n;
  logic [IN:0]     vec, vec_n;
  logic [FW-1:0]   acc, acc_n, acc_sum, pop;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [IN-1:0]   inp_n;
  logic            busy_n, done_n, perf_n;
  logic [FW-1:0]   fit_n;
  logic [OUT-1:0]  match;

  // Count output bits that agree with the target slice of the current vector
  always_comb begin
    match = ~(out_dut ^ target[int'(vec[IN-1:0])*OUT +: OUT]);
    pop   = '0;
    for (int i = 0; i < OUT; i++) pop = pop + FW'(match[i]);
    acc_sum = acc + pop;
  end

  // Next-state and registered-output logic; abort overrides any transition
  always_comb begin
    state_n = state;
    vec_n   = vec;
    acc_n   = acc;
    wcnt_n  = wcnt;
    inp_n   = inp;
    busy_n  = busy;
    done_n  = 1'b0;
    fit_n   = fitness;
    perf_n  = perfect;
    case (state)
      IDLE: if (start) begin
        vec_n   = '0;
        acc_n   = '0;
        wcnt_n  = '0;
        inp_n   = '0;
        busy_n  = 1'b1;
        state_n = APPLY;
      end
      APPLY: begin
        if (wcnt == WAIT_END) state_n = SAMPLE;
        else                  wcnt_n  = wcnt + 1'b1;
      end
      SAMPLE: begin
        acc_n = acc_sum;
        if (vec == VEC_LAST) begin
          fit_n   = acc_sum;
          perf_n  = (acc_sum == FIT_MAX);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end else begin
          vec_n   = vec + 1'b1;
          inp_n   = vec_n[IN-1:0];
          wcnt_n  = '0;
          state_n = APPLY;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      inp_n   = '0;
      done_n  = 1'b0;
      fit_n   = fitness;
      perf_n  = perfect;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vec     <= '0;
      acc     <= '0;
      wcnt    <= '0;
      inp     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fitness <= '0;
      perfect <= 1'b0;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      acc     <= acc_n;
      wcnt    <= wcnt_n;
      inp     <= inp_n;
      busy    <= busy_n;
      done    <= done_n;
      fitness <= fit_n;
      perfect <= perf_n;
    end
  end

endmodule

// File: tb/tb_fitness_sweeper.sv
// Directed bench: two sweepers (IN=2/OUT=1/SETTLE=1 and IN=2/OUT=2/SETTLE=0)
// driven by behavioural circuit models; expected fitness is pushed to a
// scoreboard at start and compared when done pulses.
module tb_fitness_sweeper;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] target;
  logic       out_dut;
  logic [1:0] inp;
  logic       busy, done, perfect;
  logic [2:0] fitness;

  logic       start2, abort2;
  logic [7:0] target2;
  logic [1:0] out2, inp2;
  logic       busy2, done2, perfect2;
  logic [3:0] fitness2;

  int mdl, mdl2;
  int checks = 0, errors = 0;

  typedef struct { int f; int p; } exp_t;
  exp_t sb[$];
  exp_t sb2[$];

  always #5 clk = ~clk;

  // Circuit models: 0 = XOR, 1 = AND; second: 0 = swapped bits, 1 = identity
  always_comb out_dut = (mdl == 0) ? ^inp : &inp;
  always_comb out2    = (mdl2 == 0) ? {inp2[0], inp2[1]} : inp2;

  fitness_sweeper #(.IN(2), .OUT(1), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
    .out_dut(out_dut), .inp(inp), .busy(busy), .done(done),
    .fitness(fitness), .perfect(perfect));

  fitness_sweeper #(.IN(2), .OUT(2), .SETTLE(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .target(target2),
    .out_dut(out2), .inp(inp2), .busy(busy2), .done(done2),
    .fitness(fitness2), .perfect(perfect2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_fit(input int m, input logic [3:0] t);
    int f = 0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] x;
      logic o;
      x = 2'(v);
      o = (m == 0) ? ^x : &x;
      if (o == t[v]) f++;
    end
    return f;
  endfunction

  function automatic int model_fit2(input int m, input logic [7:0] t);
    int f = 0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] x, o, e;
      x = 2'(v);
      o = (m == 0) ? {x[0], x[1]} : x;
      e = t[2*v +: 2];
      for (int b = 0; b < 2; b++) if (o[b] == e[b]) f++;
    end
    return f;
  endfunction

  // One run on the first sweeper; cycle 0 is the start cycle. Zero disables
  // the optional restart/abort/reset cycle.
  task automatic do_run(input int m, input int restart_c, input int abort_c,
                        input int rst_c, output int dcyc, output int dcnt);
    bit alive = 1'b1;
    exp_t e;
    mdl = m;
    if (abort_c == 0 && rst_c == 0)
      sb.push_back('{model_fit(m, target), int'(model_fit(m, target) == 4)});
    start = 1'b1;
    step();
    start = 1'b0;
    dcyc = -1;
    dcnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (done) begin
        dcnt++;
        dcyc = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("fitness", 32'(fitness), 32'(e.f));
          chk("perfect", 32'(perfect), 32'(e.p));
        end else chk("unexpected_done", 32'(done), 32'd0);
      end
      if (alive && c <= 12) begin
        chk("inp", 32'(inp), 32'((c - 1) / 3));
        chk("busy_run", 32'(busy), 32'd1);
      end
      if (alive && c == 13) chk("busy_done", 32'(busy), 32'd0);
      start = (c == restart_c);
      abort = (c == abort_c);
      rst   = (c == rst_c);
      step();
      start = 1'b0;
      abort = 1'b0;
      if (c == abort_c) begin
        alive = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_inp", 32'(inp), 32'd0);
      end
      if (c == rst_c) begin
        alive = 1'b0;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fitness", 32'(fitness), 32'd0);
        chk("rst_perfect", 32'(perfect), 32'd0);
        chk("rst_inp", 32'(inp), 32'd0);
      end
    end
  endtask

  // One run on the second sweeper (SETTLE=0, OUT=2): 2 cycles per vector
  task automatic do_run2(input int m, output int dcyc, output int dcnt);
    exp_t e;
    mdl2 = m;
    sb2.push_back('{model_fit2(m, target2), int'(model_fit2(m, target2) == 8)});
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    dcyc = -1;
    dcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done2) begin
        dcnt++;
        dcyc = c;
        if (sb2.size() > 0) begin
          e = sb2.pop_front();
          chk("fitness2", 32'(fitness2), 32'(e.f));
          chk("perfect2", 32'(perfect2), 32'(e.p));
        end else chk("unexpected_done2", 32'(done2), 32'd0);
      end
      if (c <= 8) chk("inp2", 32'(inp2), 32'((c - 1) / 2));
      step();
    end
  endtask

  initial begin
    int dc, dn;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    target = 4'b0110; target2 = 8'b11_10_01_00; mdl = 0; mdl2 = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_fitness", 32'(fitness), 32'd0);
    chk("reset_perfect", 32'(perfect), 32'd0);
    chk("reset_inp", 32'(inp), 32'd0);
    chk("reset_fitness2", 32'(fitness2), 32'd0);

    // XOR model: perfect score
    do_run(0, 0, 0, 0, dc, dn);
    chk("run1_done_cycle", 32'(dc), 32'd13);
    chk("run1_done_count", 32'(dn), 32'd1);

    // AND model: one match
    do_run(1, 0, 0, 0, dc, dn);
    chk("run2_done_cycle", 32'(dc), 32'd13);
    chk("run2_done_count", 32'(dn), 32'd1);

    // start while busy is ignored
    do_run(0, 6, 0, 0, dc, dn);
    chk("run3_done_cycle", 32'(dc), 32'd13);
    chk("run3_done_count", 32'(dn), 32'd1);

    // abort mid-run keeps the previous result
    do_run(1, 0, 5, 0, dc, dn);
    chk("abort_done_count", 32'(dn), 32'd0);
    chk("abort_fitness", 32'(fitness), 32'd4);
    chk("abort_perfect", 32'(perfect), 32'd1);

    // abort while idle has no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_fitness", 32'(fitness), 32'd4);

    // reset mid-run, then a clean run
    do_run(0, 0, 0, 7, dc, dn);
    chk("rst_done_count", 32'(dn), 32'd0);
    do_run(0, 0, 0, 0, dc, dn);
    chk("run5_done_cycle", 32'(dc), 32'd13);
    chk("run5_done_count", 32'(dn), 32'd1);

    // second sweeper: swapped-bit model, then identity model (perfect)
    do_run2(0, dc, dn);
    chk("run6a_done_cycle", 32'(dc), 32'd9);
    chk("run6a_done_count", 32'(dn), 32'd1);
    do_run2(1, dc, dn);
    chk("run6b_done_cycle", 32'(dc), 32'd9);
    chk("run6b_done_count", 32'(dn), 32'd1);
    chk("run6b_fitness", 32'(fitness2), 32'd8);

    chk("sb_empty", 32'(sb.size() + sb2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
